// File: rtl/processor_trace_buffer.sv
// rtl/processor_trace_buffer.sv - circular execution trace buffer for the single-cycle ARM core
// Records PC/Instr/ALUResult/WriteData/MemWrite per qualified cycle; indexed readout, oldest entry first.
module processor_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              trig_sel,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W:0]   post_count,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Instr,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_alu,
  output logic [DATA_W-1:0] rd_wdata,
  output logic              rd_memwrite,
  output logic              rd_valid,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W:0]   entries
);

  localparam int REC_W = 4 * DATA_W + 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t              state, state_next;
  logic [1:0]          mode_q;
  logic                trig_sel_q;
  logic [DATA_W-1:0]   trig_value_q;
  logic [ADDR_W:0]     post_q;
  logic [ADDR_W:0]     post_left;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     entries_q;
  logic                triggered_q;
  logic [REC_W-1:0]    mem [DEPTH];
  logic [REC_W-1:0]    rd_data;
  logic                rd_valid_q;
  logic                match;
  logic                wr_en;
  logic                trig_hit;
  logic [ADDR_W-1:0]   rd_phys;
  logic                rd_in_range;

  assign match = trig_sel_q ? (Instr == trig_value_q) : (PC == trig_value_q);

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    trig_hit   = 1'b0;
    case (state)
      S_ARMED: begin
        if (cap_en) begin
          // mode 10 keeps a rolling pre-trigger history; mode 01 writes only from the trigger on
          if (mode_q == 2'b10) wr_en = 1'b1;
          if (match) begin
            trig_hit = 1'b1;
            wr_en    = 1'b1;
            if (mode_q == 2'b10 && post_q == '0) state_next = S_DONE;
            else                                  state_next = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        wr_en = cap_en;
        case (mode_q)
          2'b01:   if (cap_en && entries_q == LAST) state_next = S_DONE;
          2'b10:   if (cap_en && post_left == ONE)  state_next = S_DONE;
          default: if (stop) state_next = S_DONE;
        endcase
      end
      default: ;
    endcase
    if (arm) begin
      wr_en      = 1'b0;
      trig_hit   = 1'b0;
      state_next = (mode == 2'b01 || mode == 2'b10) ? S_ARMED : S_CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mode_q       <= 2'b00;
      trig_sel_q   <= 1'b0;
      trig_value_q <= '0;
      post_q       <= '0;
      post_left    <= '0;
      wr_ptr       <= '0;
      entries_q    <= '0;
      triggered_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (arm) begin
        mode_q       <= (mode == 2'b11) ? 2'b00 : mode;
        trig_sel_q   <= trig_sel;
        trig_value_q <= trig_value;
        post_q       <= (post_count > LAST) ? LAST : post_count;
        post_left    <= '0;
        wr_ptr       <= '0;
        entries_q    <= '0;
        triggered_q  <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (entries_q != FULL) entries_q <= entries_q + ONE;
        end
        if (trig_hit) begin
          triggered_q <= 1'b1;
          post_left   <= post_q;
        end else if (wr_en && state == S_CAPTURE && post_left != '0) begin
          post_left <= post_left - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr] <= {PC, Instr, ALUResult, WriteData, MemWrite};
  end

  // Oldest entry sits entries_q slots behind the write pointer; a full buffer wraps to wr_ptr itself.
  assign rd_phys     = wr_ptr - entries_q[ADDR_W-1:0] + rd_idx;
  assign rd_in_range = {1'b0, rd_idx} < entries_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_phys] : '0;
    end
  end

  assign rd_pc       = rd_data[REC_W-1 -: DATA_W];
  assign rd_instr    = rd_data[3*DATA_W -: DATA_W];
  assign rd_alu      = rd_data[2*DATA_W -: DATA_W];
  assign rd_wdata    = rd_data[DATA_W -: DATA_W];
  assign rd_memwrite = rd_data[0];
  assign rd_valid    = rd_valid_q;
  assign busy        = (state == S_ARMED) || (state == S_CAPTURE);
  assign done        = (state == S_DONE);
  assign triggered   = triggered_q;
  assign entries     = entries_q;

endmodule

// File: tb/tb_processor_trace_buffer.sv
// tb/tb_processor_trace_buffer.sv - self-checking bench for processor_trace_buffer
// A queue-based session model is compared every cycle; literal checks pin key scenarios.
module tb_processor_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        trig_sel = 1'b0;
  logic [31:0] trig_value = '0;
  logic [4:0]  post_count = '0;
  logic        cap_en = 1'b0;
  logic [31:0] PC = '0, Instr = '0, ALUResult = '0, WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic [31:0] rd_pc, rd_instr, rd_alu, rd_wdata;
  logic        rd_memwrite, rd_valid, busy, triggered, done;
  logic [4:0]  entries;

  processor_trace_buffer #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
    .trig_sel(trig_sel), .trig_value(trig_value), .post_count(post_count),
    .cap_en(cap_en), .PC(PC), .Instr(Instr), .ALUResult(ALUResult),
    .WriteData(WriteData), .MemWrite(MemWrite), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_wdata(rd_wdata),
    .rd_memwrite(rd_memwrite), .rd_valid(rd_valid), .busy(busy),
    .triggered(triggered), .done(done), .entries(entries)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sessions as a plain list of records, newest at the back.
  typedef struct packed {
    logic [31:0] pc, instr, alu, wdata;
    logic        mw;
  } rec_t;

  rec_t q[$];
  int   m_state = 0;          // 0 idle, 1 armed, 2 capture, 3 done
  int   m_mode = 0, m_post = 0, m_left = 0;
  logic m_sel = 0, m_trig = 0, m_rv = 0;
  logic [31:0] m_val = 0;
  rec_t m_rd = '0;
  int   ncyc = 0;

  function automatic void push(input rec_t r);
    q.push_back(r);
    if (q.size() > 16) void'(q.pop_front());
  endfunction

  always @(posedge clk) begin
    rec_t r;
    logic samp, hit;
    ncyc++;
    r = '{pc: PC, instr: Instr, alu: ALUResult, wdata: WriteData, mw: MemWrite};
    if (reset) begin
      m_state = 0; q.delete(); m_trig = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_rv = rd_en;
      if (rd_en) m_rd = (int'(rd_idx) < q.size()) ? q[rd_idx] : '0;
      if (arm) begin
        q.delete(); m_trig = 0;
        m_mode  = (mode == 2'd3) ? 0 : int'(mode);
        m_sel   = trig_sel; m_val = trig_value;
        m_post  = (post_count > 15) ? 15 : int'(post_count);
        m_state = (m_mode == 0) ? 2 : 1;
      end else begin
        samp = cap_en && (m_state == 1 || m_state == 2);
        hit  = samp && m_state == 1 && ((m_sel ? Instr : PC) == m_val);
        if (m_state == 1 && samp) begin
          if (m_mode == 2 || hit) push(r);
          if (hit) begin
            m_trig = 1;
            if (m_mode == 2 && m_post == 0) m_state = 3;
            else begin m_state = 2; m_left = m_post; end
          end
        end else if (m_state == 2) begin
          if (m_mode == 0) begin
            if (samp) push(r);
            if (stop) m_state = 3;
          end else if (m_mode == 1) begin
            if (samp) begin push(r); if (q.size() == 16) m_state = 3; end
          end else if (samp) begin
            push(r); m_left--; if (m_left == 0) m_state = 3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ncyc > 0) begin
      chk("busy", busy, m_state == 1 || m_state == 2);
      chk("done", done, m_state == 3);
      chk("triggered", triggered, m_trig);
      chk("entries", entries, q.size());
      chk("rd_valid", rd_valid, m_rv);
      if (m_rv) begin
        chk("rd_pc", rd_pc, m_rd.pc);
        chk("rd_instr", rd_instr, m_rd.instr);
        chk("rd_alu", rd_alu, m_rd.alu);
        chk("rd_wdata", rd_wdata, m_rd.wdata);
        chk("rd_memwrite", rd_memwrite, m_rd.mw);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_arm(input logic [1:0] md, input logic sel, input logic [31:0] val,
                        input logic [4:0] pcnt);
    mode = md; trig_sel = sel; trig_value = val; post_count = pcnt;
    arm = 1'b1; cap_en = 1'b0; cyc(); arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cap_en = 1'b0; cyc(); stop = 1'b0;
  endtask

  task automatic smp(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                     input logic [31:0] w, input logic m, input logic ce);
    PC = p; Instr = i; ALUResult = a; WriteData = w; MemWrite = m; cap_en = ce;
    rd_en = 1'b1; rd_idx = rd_idx + 4'd3;
    cyc();
    cap_en = 1'b0; rd_en = 1'b0;
  endtask

  // field: 0 pc, 1 instr, 2 alu, 3 wdata
  task automatic rd_lit(input logic [3:0] idx, input int field, input logic [31:0] exp,
                        input string nm);
    logic [31:0] v;
    rd_en = 1'b1; rd_idx = idx; cap_en = 1'b0; cyc(); rd_en = 1'b0;
    case (field)
      0: v = rd_pc;
      1: v = rd_instr;
      2: v = rd_alu;
      default: v = rd_wdata;
    endcase
    chk(nm, v, exp);
  endtask

  logic [31:0] prog [4];
  localparam logic [31:0] NOP = 32'he1a00000;

  initial begin
    prog[0] = 32'he3a00001; prog[1] = 32'he3a01002;
    prog[2] = 32'he0802001; prog[3] = 32'he0803002;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_entries", entries, 5'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);

    // mode 00 program run; the arm cycle carries cap_en=1 but must not be sampled
    mode = 2'b00; arm = 1'b1; cap_en = 1'b1; PC = 32'hFF; cyc(); arm = 1'b0;
    for (int k = 0; k < 4; k++) smp(32'(4 * k), prog[k], 32'(k + 1), 32'h0, 1'b0, 1'b1);
    do_stop();
    chk("m00_done", done, 1'b1);
    chk("m00_entries", entries, 5'd4);
    rd_lit(4'd0, 1, 32'he3a00001, "m00_idx0_instr");
    rd_lit(4'd2, 2, 32'd3, "m00_idx2_alu");
    rd_lit(4'd3, 2, 32'd4, "m00_idx3_alu");
    rd_lit(4'd4, 0, 32'd0, "m00_oob_pc");
    chk("m00_oob_valid", rd_valid, 1'b1);
    chk("m00_oob_mw", rd_memwrite, 1'b0);

    // mode 00 wrap
    do_arm(2'b00, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 20; k++) smp(32'(4 * k), 32'hA000 + 32'(k), 32'(k * 7), 32'(k), k[0], 1'b1);
    do_stop();
    chk("wrap_entries", entries, 5'd16);
    rd_lit(4'd0, 0, 32'h10, "wrap_idx0_pc");
    rd_lit(4'd15, 0, 32'h4C, "wrap_idx15_pc");

    // mode 01 on PC==8; stop pulses are ignored here
    do_arm(2'b01, 1'b0, 32'h8, 5'd0);
    for (int k = 0; k < 26; k++) begin
      if (k == 6) stop = 1'b1;
      smp(32'(4 * k), 32'hB000 + 32'(k), 32'(k), 32'(k * 3), 1'b1, 1'b1);
      stop = 1'b0;
      if (k == 1) chk("m01_pre_entries", entries, 5'd0);
    end
    chk("m01_done", done, 1'b1);
    chk("m01_triggered", triggered, 1'b1);
    chk("m01_entries", entries, 5'd16);
    rd_lit(4'd0, 0, 32'h8, "m01_idx0_pc");
    rd_lit(4'd15, 0, 32'h44, "m01_idx15_pc");

    // mode 10 on Instr==ADD R2,R0,R1 with 2 post-trigger samples
    do_arm(2'b10, 1'b1, 32'he0802001, 5'd2);
    for (int k = 0; k < 4; k++) smp(32'(4 * k), prog[k], 32'(k + 1), 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) smp(32'h10 + 32'(4 * k), NOP, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("m10_done", done, 1'b1);
    chk("m10_entries", entries, 5'd5);
    rd_lit(4'd4, 1, NOP, "m10_newest_instr");
    rd_lit(4'd4, 0, 32'h10, "m10_newest_pc");
    rd_lit(4'd2, 1, 32'he0802001, "m10_trig_instr");

    // gating in mode 00
    do_arm(2'b00, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 8; k++) smp(32'h100 + 32'(4 * k), 32'h1, 32'h2, 32'h3, 1'b0, ~k[0]);
    do_stop();
    chk("gate_entries", entries, 5'd4);

    // gated match must not trigger in mode 01
    do_arm(2'b01, 1'b0, 32'h8, 5'd0);
    smp(32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    smp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    smp(32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("gate_trig", triggered, 1'b0);
    chk("gate_m01_entries", entries, 5'd0);

    // re-arm mid-CAPTURE after a trigger
    smp(32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    smp(32'hC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    do_arm(2'b00, 1'b0, 32'h0, 5'd0);
    chk("rearm_entries", entries, 5'd0);
    chk("rearm_trig", triggered, 1'b0);
    chk("rearm_busy", busy, 1'b1);

    // arm and stop together: arm wins
    stop = 1'b1; do_arm(2'b00, 1'b0, 32'h0, 5'd0); stop = 1'b0;
    chk("armstop_busy", busy, 1'b1);

    // post_count clamped to 15
    do_arm(2'b10, 1'b0, 32'h20, 5'd31);
    for (int k = 0; k < 40; k++) smp(32'(4 * k), 32'hC000 + 32'(k), 32'(k), 32'(k), k[1], 1'b1);
    chk("clamp_done", done, 1'b1);
    chk("clamp_entries", entries, 5'd16);
    rd_lit(4'd0, 0, 32'h20, "clamp_idx0_pc");

    // reset mid-ARMED
    do_arm(2'b01, 1'b1, 32'hDEADBEEF, 5'd3);
    smp(32'h0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1);
    rd_en = 1'b1; reset = 1'b1; cyc(); reset = 1'b0; rd_en = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_rd_valid", rd_valid, 1'b0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
